// File: rtl/arcade_input_conditioner.sv
// Arcade input conditioner.
// Cleans up the HPS joystick word before it reaches the game core. Each
// button is synchronized and debounced. Opposing directions cancel to
// neutral. The coin button becomes frame-timed pulses with a gap after
// each pulse and room for one queued request. The pause button gives a
// one-cycle toggle strobe.

module arcade_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int COIN_FRAMES     = 3,
    parameter int COIN_GAP_FRAMES = 2,
    parameter int CNT_W           = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joy_in,
    input  logic        vblank,
    input  logic        paused,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        fire,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin_busy,
    output logic        pause_toggle
);

    // The frame counter must hold the larger of the two frame limits, and
    // it is never narrower than one bit.
    localparam int FRAME_MAX = (COIN_FRAMES > COIN_GAP_FRAMES) ? COIN_FRAMES : COIN_GAP_FRAMES;
    localparam int FCNT_W    = ($clog2(FRAME_MAX) < 1) ? 1 : $clog2(FRAME_MAX);

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] COIN_LAST = FCNT_W'(COIN_FRAMES - 1);
    localparam logic [FCNT_W-1:0] GAP_LAST  = FCNT_W'(COIN_GAP_FRAMES - 1);

    // Bit positions inside the joystick word.
    localparam int B_RIGHT  = 0;
    localparam int B_LEFT   = 1;
    localparam int B_DOWN   = 2;
    localparam int B_UP     = 3;
    localparam int B_FIRE   = 4;
    localparam int B_START1 = 5;
    localparam int B_START2 = 6;
    localparam int B_COIN   = 7;
    localparam int B_PAUSE  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } coinState_t;

    logic [8:0]        r_sync1;
    logic [8:0]        r_sync2;
    logic [8:0]        r_deb;
    logic [CNT_W-1:0]  r_debCnt [9];

    logic              r_up;
    logic              r_down;
    logic              r_left;
    logic              r_right;
    logic              r_fire;
    logic              r_start1;
    logic              r_start2;

    logic              r_pausePrev;
    logic              r_pauseToggle;

    logic              r_coinPrev;
    logic              r_vblankD;

    coinState_t        r_state;
    coinState_t        w_stateNext;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcntNext;
    logic              r_pending;
    logic              w_pendingNext;

    logic              w_coinReq;
    logic              w_tick;
    logic              w_unusedJoy;

    // Bits 9-15 of the joystick word carry nothing this block uses.
    assign w_unusedJoy = ^joy_in[15:9];

    // Two-flop synchronizer for the nine used joystick bits.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= joy_in[8:0];
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce. A bit flips only after it has disagreed with its
    // debounced value for DEBOUNCE_CYCLES samples in a row. Any agreement
    // restarts the count, and the counter is cleared at the flip, so it
    // never runs past DEBOUNCE_CYCLES-1.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < 9; i++) begin
                r_debCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_debCnt[i] <= '0;
                end else if (r_debCnt[i] >= DEB_LAST) begin
                    r_deb[i]    <= ~r_deb[i];
                    r_debCnt[i] <= '0;
                end else begin
                    r_debCnt[i] <= r_debCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register the player outputs. Opposing directions cancel to neutral.
    // The buttons share the same register stage so they line up with the
    // directions.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_up     <= 1'b0;
            r_down   <= 1'b0;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_fire   <= 1'b0;
            r_start1 <= 1'b0;
            r_start2 <= 1'b0;
        end else begin
            r_up     <= r_deb[B_UP] & ~r_deb[B_DOWN];
            r_down   <= r_deb[B_DOWN] & ~r_deb[B_UP];
            r_left   <= r_deb[B_LEFT] & ~r_deb[B_RIGHT];
            r_right  <= r_deb[B_RIGHT] & ~r_deb[B_LEFT];
            r_fire   <= r_deb[B_FIRE];
            r_start1 <= r_deb[B_START1];
            r_start2 <= r_deb[B_START2];
        end
    end

    // One-cycle strobe on the debounced pause press. Holding the button
    // does not repeat the strobe.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_pausePrev   <= 1'b0;
            r_pauseToggle <= 1'b0;
        end else begin
            r_pausePrev   <= r_deb[B_PAUSE];
            r_pauseToggle <= r_deb[B_PAUSE] & ~r_pausePrev;
        end
    end

    // Edge-detect history for the debounced coin and for vblank.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_coinPrev <= 1'b0;
            r_vblankD  <= 1'b0;
        end else begin
            r_coinPrev <= r_deb[B_COIN];
            r_vblankD  <= vblank;
        end
    end

    // A coin request is the debounced press edge, so a held coin counts
    // once. Frame ticks do not count while the CPU is paused.
    assign w_coinReq = r_deb[B_COIN] & ~r_coinPrev;
    assign w_tick    = vblank & ~r_vblankD & ~paused;

    // Coin FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= IDLE;
            r_fcnt    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_fcnt    <= w_fcntNext;
            r_pending <= w_pendingNext;
        end
    end

    // Coin FSM next state. coin1 is held high for COIN_FRAMES ticks and then
    // low for COIN_GAP_FRAMES ticks. One extra request can wait during a
    // pulse or a gap. A request that lands on the final gap tick restarts
    // the pulse directly, so it is not lost.
    always_comb begin
        w_stateNext   = r_state;
        w_fcntNext    = r_fcnt;
        w_pendingNext = r_pending;
        case (r_state)
            IDLE: begin
                if (w_coinReq) begin
                    w_stateNext = ACTIVE;
                    w_fcntNext  = '0;
                end
            end
            ACTIVE: begin
                if (w_coinReq && !r_pending) begin
                    w_pendingNext = 1'b1;
                end
                if (w_tick) begin
                    if (r_fcnt == COIN_LAST) begin
                        w_stateNext = GAP;
                        w_fcntNext  = '0;
                    end else begin
                        w_fcntNext = r_fcnt + FCNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (w_coinReq && !r_pending) begin
                    w_pendingNext = 1'b1;
                end
                if (w_tick) begin
                    if (r_fcnt == GAP_LAST) begin
                        w_fcntNext = '0;
                        if (r_pending || w_coinReq) begin
                            w_stateNext   = ACTIVE;
                            w_pendingNext = 1'b0;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_fcntNext = r_fcnt + FCNT_W'(1);
                    end
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_fcntNext    = '0;
                w_pendingNext = 1'b0;
            end
        endcase
    end

    assign up           = r_up;
    assign down         = r_down;
    assign left         = r_left;
    assign right        = r_right;
    assign fire         = r_fire;
    assign start1       = r_start1;
    assign start2       = r_start2;
    assign coin1        = (r_state == ACTIVE);
    assign coin_busy    = (r_state != IDLE);
    assign pause_toggle = r_pauseToggle;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Bench for arcade_input_conditioner with short debounce. The stimulus
// process queues every expected output change with its expected cycle.
// The monitor pops and compares an entry each time the output vector
// changes.

module tb_arcade_input_conditioner;

    localparam logic [9:0] V_IDLE = 10'b0000000000;
    localparam logic [9:0] V_ACT  = 10'b0110000000;
    localparam logic [9:0] V_GAP  = 10'b0100000000;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [15:0] joyIn  = 16'h0000;
    logic        vblank = 1'b0;
    logic        paused = 1'b0;

    logic up, down, left, right, fire, start1, start2, coin1, coinBusy, pauseToggle;
    logic [9:0] outVec;

    int   cyc        = 0;
    int   checkCount = 0;
    int   passCount  = 0;
    bit   monitorOn  = 1'b0;
    logic [9:0] prevOuts = '0;

    int         expCycQ[$];
    logic [9:0] expValQ[$];
    string      expNameQ[$];

    logic [15:0] dirJoy [8] = '{16'h0008, 16'h000C, 16'h0004, 16'h0000,
                                16'h0002, 16'h0003, 16'h0001, 16'h0000};
    logic [9:0]  dirExp [8] = '{10'b0000001000, 10'b0000000000, 10'b0000000100, 10'b0000000000,
                                10'b0000000010, 10'b0000000000, 10'b0000000001, 10'b0000000000};

    assign outVec = {pauseToggle, coinBusy, coin1, start2, start1, fire, up, down, left, right};

    arcade_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .COIN_FRAMES     (3),
        .COIN_GAP_FRAMES (2),
        .CNT_W           (16)
    ) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .joy_in       (joyIn),
        .vblank       (vblank),
        .paused       (paused),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .fire         (fire),
        .start1       (start1),
        .start2       (start2),
        .coin1        (coin1),
        .coin_busy    (coinBusy),
        .pause_toggle (pauseToggle)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one observation. A negative expected cycle skips the timing part.
    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp,
                               input int actCyc, input int expCyc);
        checkCount++;
        if (act === exp && (expCyc < 0 || actCyc == expCyc)) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                     name, act, actCyc, exp, expCyc);
        end
    endtask

    task automatic expectAt(input int delta, input logic [9:0] vec, input string name);
        expCycQ.push_back(cyc + delta);
        expValQ.push_back(vec);
        expNameQ.push_back(name);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] j);
        joyIn = j;
    endtask

    // One vblank rising edge, then gapAfter idle cycles before returning.
    task automatic tick(input bit doExpect, input logic [9:0] vec, input string name, input int gapAfter);
        if (doExpect) expectAt(1, vec, name);
        vblank = 1'b1;
        @(negedge clk);
        vblank = 1'b0;
        repeat (gapAfter) @(negedge clk);
    endtask

    task automatic quietTicks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, V_IDLE, "", 19);
    endtask

    task automatic pressCoin();
        applyStimulus(16'h0080);
        waitCycles(8);
        applyStimulus(16'h0000);
        waitCycles(8);
    endtask

    // Monitor: every change of the output vector must match the next queued expectation.
    always @(negedge clk) begin
        if (monitorOn && (outVec !== prevOuts)) begin
            if (expCycQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedChange: got %b at cycle %0d, expected no change from %b",
                         outVec, cyc, prevOuts);
            end else begin
                checkOutput(expNameQ.pop_front(), outVec, expValQ.pop_front(), cyc, expCycQ.pop_front());
            end
            prevOuts = outVec;
        end
    end

    // Stimulus sequence.
    initial begin
        reset = 1'b1;
        applyStimulus(16'h01FF);
        waitCycles(5);
        checkOutput("resetState", outVec, V_IDLE, cyc, -1);
        prevOuts  = outVec;
        monitorOn = 1'b1;

        // Release with everything pressed: buttons, a coin pulse and a pause strobe appear. Directions cancel.
        reset = 1'b0;
        expectAt(7, 10'b1111110000, "bootButtons");
        expectAt(8, 10'b0111110000, "bootToggleEnd");
        waitCycles(12);

        // Reset in mid-pulse clears everything on the next edge.
        reset = 1'b1;
        applyStimulus(16'h0000);
        expectAt(1, V_IDLE, "resetClears");
        waitCycles(3);
        reset = 1'b0;
        waitCycles(10);

        // A 3-cycle fire glitch is filtered out. A 10-cycle press gets through.
        applyStimulus(16'h0010);
        waitCycles(3);
        applyStimulus(16'h0000);
        waitCycles(10);
        applyStimulus(16'h0010);
        expectAt(7, 10'b0000010000, "fireRise");
        waitCycles(10);
        applyStimulus(16'h0000);
        expectAt(7, V_IDLE, "fireFall");
        waitCycles(12);

        // Direction resolution table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(dirJoy[i]);
            expectAt(7, dirExp[i], $sformatf("dir%0d", i));
            waitCycles(10);
        end

        // Single coin: three ticks high, two ticks of gap, then idle.
        applyStimulus(16'h0080);
        expectAt(7, V_ACT, "coinStart");
        waitCycles(10);
        applyStimulus(16'h0000);
        waitCycles(10);
        quietTicks(2);
        tick(1'b1, V_GAP, "coinGap", 19);
        quietTicks(1);
        tick(1'b1, V_IDLE, "coinIdle", 19);
        quietTicks(1);

        // Three presses: the second is queued, the third is dropped.
        applyStimulus(16'h0080);
        expectAt(7, V_ACT, "multiStart");
        waitCycles(8);
        applyStimulus(16'h0000);
        waitCycles(8);
        pressCoin();
        pressCoin();
        waitCycles(5);
        quietTicks(2);
        tick(1'b1, V_GAP, "multiGap1", 19);
        quietTicks(1);
        tick(1'b1, V_ACT, "multiSecondPulse", 19);
        quietTicks(2);
        tick(1'b1, V_GAP, "multiGap2", 19);
        quietTicks(1);
        tick(1'b1, V_IDLE, "multiIdle", 19);
        quietTicks(2);

        // Pause freezes the pulse for five ticks. The remaining ticks finish it afterwards.
        applyStimulus(16'h0080);
        expectAt(7, V_ACT, "pauseStart");
        waitCycles(10);
        applyStimulus(16'h0000);
        waitCycles(10);
        quietTicks(1);
        paused = 1'b1;
        quietTicks(5);
        paused = 1'b0;
        waitCycles(3);
        quietTicks(1);
        tick(1'b1, V_GAP, "pauseResumeGap", 19);
        quietTicks(1);
        tick(1'b1, V_IDLE, "pauseIdle", 19);
        quietTicks(1);

        // A request on the final gap tick goes straight back to ACTIVE and is used only once.
        applyStimulus(16'h0080);
        expectAt(7, V_ACT, "edgeStart");
        waitCycles(10);
        applyStimulus(16'h0000);
        waitCycles(10);
        quietTicks(2);
        tick(1'b1, V_GAP, "edgeGap", 19);
        tick(1'b0, V_IDLE, "", 13);
        applyStimulus(16'h0080);
        waitCycles(6);
        tick(1'b1, V_ACT, "edgeRequeue", 19);
        applyStimulus(16'h0000);
        waitCycles(10);
        quietTicks(2);
        tick(1'b1, V_GAP, "edgeGap2", 19);
        quietTicks(1);
        tick(1'b1, V_IDLE, "edgeIdle", 19);
        quietTicks(2);

        // A held pause button gives a single strobe.
        applyStimulus(16'h0100);
        expectAt(7, 10'b1000000000, "toggleHigh");
        expectAt(8, V_IDLE, "toggleLow");
        waitCycles(100);
        applyStimulus(16'h0000);
        waitCycles(20);

        monitorOn = 1'b0;
        @(posedge clk);
        #1;
        while (expCycQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL %s: got no change, expected %b at cycle %0d",
                     expNameQ.pop_front(), expValQ.pop_front(), expCycQ.pop_front());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected sequence completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/arcade_input_conditioner.md
Name: arcade_input_conditioner

Overview:
- Sits between the HPS joystick words and the game core's player/coin/start inputs.
- Debounces the merged joystick word and resolves opposing directions to neutral.
- Shapes the coin input into frame-timed pulses, with a gap after each pulse and one queued request.
- Produces a one-cycle pause toggle strobe for the pause block.

Parameters:
- DEBOUNCE_CYCLES, 12000: consecutive stable cycles required before a debounced bit changes (1 ms at 12 MHz). Must be ≥1.
- COIN_FRAMES, 3: number of frame ticks coin1 is held high per coin. Must be ≥1.
- COIN_GAP_FRAMES, 2: number of frame ticks coin1 is forced low after each pulse. Must be ≥1.
- CNT_W, 16: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- joy_in  in  16  OR of both joystick words. Bit map: 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start1, 6 start2, 7 coin, 8 pause. Bits 9-15 are ignored.
- vblank  in  1  core vertical blank. Its rising edge is the frame tick.
- paused  in  1  CPU pause active. While high, the coin FSM ignores frame ticks.
- up, down, left, right  out  1 each  conditioned directions.
- fire, start1, start2  out  1 each  debounced buttons.
- coin1  out  1  shaped coin pulse.
- coin_busy  out  1  high whenever the coin FSM is not in IDLE.
- pause_toggle  out  1  one-cycle strobe on the debounced pause rising edge.

Behaviour:
- Reset: every output is 0. All debounced bits, debounce counters, vblank_d, pending and the frame counter are cleared. State is IDLE. Reset dominates every other event in the same cycle.
- Input sync: joy_in[8:0] passes through a 2-flop synchronizer. Latency from joy_in to the synchronized value is 2 cycles.
- Debounce, per bit 0-8, each with its own counter:
  - If the synchronized bit equals the debounced bit, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced bit flips and the counter is cleared.
  - Any glitch back to the old value clears the counter.
  - Total latency from a clean edge to the debounced change is 2+DEBOUNCE_CYCLES cycles.
- Direction resolution, combinational from debounced bits, registered once:
  - up = du & ~dd; down = dd & ~du.
  - left = dl & ~dr; right = dr & ~dl.
  - Outputs fire, start1 and start2 are the debounced bits registered once, so they align with the directions.
- pause_toggle: high for exactly one cycle when the debounced pause bit goes 0→1. Holding the button gives no repeat.
- Frame tick: tick = vblank & ~vblank_d. A tick is only effective when paused = 0.
- Coin FSM, with fcnt as the frame counter:
  - Coin request event: rising edge of debounced coin.
  - IDLE: on a coin request, go to ACTIVE with fcnt=0. coin1 goes high on the next cycle.
  - ACTIVE: coin1 = 1. On each effective tick fcnt increments. At fcnt = COIN_FRAMES-1 with a tick, go to GAP with fcnt=0.
  - GAP: coin1 = 0. On each effective tick fcnt increments. At fcnt = COIN_GAP_FRAMES-1 with a tick:
    - if pending = 1, clear pending and go to ACTIVE;
    - otherwise go to IDLE.
  - A coin request arriving in ACTIVE or GAP sets pending. Only one request is queued; further requests while pending = 1 are dropped.
  - A request in the same cycle as the GAP→IDLE transition sets pending, and the FSM goes to ACTIVE instead.
  - While paused = 1, fcnt and state hold. Requests are still queued.
  - A coin held high continuously produces one pulse only.
- Width rules:
  - fcnt is sized by $clog2 of the larger of COIN_FRAMES and COIN_GAP_FRAMES, minimum 1 bit.
  - The debounce counter saturates logic: it never wraps past DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, COIN_FRAMES=3, COIN_GAP_FRAMES=2):
- Reset held 5 cycles with joy_in=16'h01FF → all outputs 0. After release, fire, start1 and start2 go to 1 at cycle 2+4+1. up/down/left/right stay 0 because opposing directions are both pressed.
- joy_in[4] pulses high for 3 cycles then low → fire never asserts. Then high for 10 cycles → fire rises at cycle 7 after the edge.
- joy_in[3]=1 alone → up=1. Then add joy_in[2]=1 → after debounce, up=0 and down=0. Then release bit 3 → down=1.
- Single coin press, ticks every 20 cycles → coin1 high for exactly 3 ticks, low for 2 ticks, then IDLE with coin_busy=0.
- Three coin presses during ACTIVE → exactly 2 pulses total, separated by a 2-tick gap; the third press is dropped.
- paused=1 midway through ACTIVE for 5 ticks → coin1 stays high and fcnt is frozen. After paused=0, the remaining ticks complete the 3-tick pulse.
- Pause bit held 100 cycles → pause_toggle is high for exactly 1 cycle.
